raid_host_arbiter: RTL and testbench

//  Shares one raid controller host port between NREQ requesters with round-robin arbitration.

---
 rtl/raid_host_arbiter.sv | 177 +++++++++++++++++
 tb/tb_raid_host_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raid_host_arbiter.sv
// raid_host_arbiter: shares one raid controller host port between NREQ requesters, one op in flight.
// Build option: define RAID_ARB_STRICT_PRIO_EN for fixed lowest-index-wins priority (default round-robin).
//
// state     | meaning
// IDLE      | controller not busy and a request pending -> grant (req_ready is decoded here)
// ISSUE     | single-cycle read/write strobe, addr/din held from the grant
// WAIT_BUSY | waiting for the controller to raise busy
// WAIT_DONE | waiting for busy to fall
// DRAIN     | DRAIN_LAT settle cycles before dout/parity/err are sampled
// RESP      | one-cycle completion pulse to the granted requester
module raid_host_arbiter #(
  parameter int NREQ       = 4,
  parameter int OP_TIMEOUT = 1024,
  parameter int DRAIN_LAT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_write,
  input  logic [NREQ*32-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_din,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_parity,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              raid_read_en,
  output logic              raid_write_en,
  output logic [31:0]       raid_addr,
  output logic [31:0]       raid_din,
  input  logic [31:0]       raid_dout,
  input  logic              raid_busy,
  input  logic              raid_parity,
  input  logic              raid_err
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = ($clog2(OP_TIMEOUT + 1) > 11) ? $clog2(OP_TIMEOUT + 1) : 11;
  localparam int DRNW = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1;
  localparam logic [CNTW-1:0] CNT_MAX   = '1;
  localparam logic [CNTW-1:0] CNT_LIMIT = CNTW'(OP_TIMEOUT);
  localparam logic [NREQ-1:0] ONE       = NREQ'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_DRAIN, S_RESP
  } state_t;

  state_t          state;
  logic [IDXW-1:0] lat_g;
  logic            lat_write;
  logic [CNTW-1:0] op_cnt;
  logic [CNTW-1:0] op_cnt_nxt;
  logic [DRNW-1:0] drain_cnt;
  logic            tmo_hit;
  logic            drain_done;
  logic [IDXW-1:0] grant_idx;
  logic [IDXW-1:0] cand;
  logic            grant_any;
  logic [31:0]     addr_arr [NREQ];
  logic [31:0]     din_arr  [NREQ];
`ifndef RAID_ARB_STRICT_PRIO_EN
  logic [IDXW-1:0] rr_ptr;
`endif

  for (genvar k = 0; k < NREQ; k++) begin : g_slice
    assign addr_arr[k] = req_addr[32*k +: 32];
    assign din_arr[k]  = req_din[32*k +: 32];
  end

  // First pending request found when scanning from the search start upward.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef RAID_ARB_STRICT_PRIO_EN
      cand = IDXW'(k);
`else
      cand = IDXW'((int'(rr_ptr) + k) % NREQ);
`endif
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Decoded rather than registered so a request withdrawn before the grant is never taken.
  assign req_ready = (state == S_IDLE && !raid_busy && grant_any && !reset) ? (ONE << grant_idx) : '0;

  always_comb begin
    op_cnt_nxt = (op_cnt == CNT_MAX) ? op_cnt : op_cnt + CNTW'(1);
    tmo_hit    = (op_cnt_nxt >= CNT_LIMIT);
    drain_done = (state == S_DRAIN && drain_cnt == '0) ||
                 (state == S_WAIT_DONE && !raid_busy && DRAIN_LAT == 0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      lat_g         <= '0;
      lat_write     <= 1'b0;
      op_cnt        <= '0;
      drain_cnt     <= '0;
`ifndef RAID_ARB_STRICT_PRIO_EN
      rr_ptr        <= '0;
`endif
      rsp_valid     <= '0;
      rsp_data      <= '0;
      rsp_parity    <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_timeout   <= 1'b0;
      raid_read_en  <= 1'b0;
      raid_write_en <= 1'b0;
      raid_addr     <= '0;
      raid_din      <= '0;
    end else begin
      raid_read_en  <= 1'b0;
      raid_write_en <= 1'b0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
      rsp_parity    <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_timeout   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!raid_busy && grant_any) begin
            lat_g         <= grant_idx;
            lat_write     <= req_write[grant_idx];
            raid_addr     <= addr_arr[grant_idx];
            raid_din      <= din_arr[grant_idx];
            raid_write_en <= req_write[grant_idx];
            raid_read_en  <= !req_write[grant_idx];
`ifndef RAID_ARB_STRICT_PRIO_EN
            rr_ptr        <= (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + IDXW'(1);
`endif
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          op_cnt <= '0;
          state  <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY, S_WAIT_DONE, S_DRAIN: begin
          op_cnt <= op_cnt_nxt;
          if (tmo_hit) begin
            rsp_valid   <= ONE << lat_g;
            rsp_timeout <= 1'b1;
            state       <= S_RESP;
          end else if (drain_done) begin
            rsp_valid  <= ONE << lat_g;
            rsp_data   <= lat_write ? 32'h0 : raid_dout;
            rsp_parity <= raid_parity;
            rsp_err    <= raid_err;
            state      <= S_RESP;
          end else begin
            case (state)
              S_WAIT_BUSY: if (raid_busy) state <= S_WAIT_DONE;
              S_WAIT_DONE: begin
                if (!raid_busy) begin
                  drain_cnt <= DRNW'(DRAIN_LAT - 1);
                  state     <= S_DRAIN;
                end
              end
              S_DRAIN: drain_cnt <= drain_cnt - DRNW'(1);
              default: ;
            endcase
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raid_host_arbiter.sv
// Directed bench for raid_host_arbiter: vector table for single ops plus hand sequences for
// power-up busy, arbitration order, timeout and reset mid-operation.
module tb_raid_host_arbiter;
  localparam int NREQ = 4;
  localparam int OP_TIMEOUT = 1024;
  localparam int DRAIN_LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_write = '0;
  logic [NREQ*32-1:0] req_addr = '0;
  logic [NREQ*32-1:0] req_din = '0;
  logic [NREQ-1:0] req_ready, rsp_valid;
  logic [31:0] rsp_data;
  logic rsp_parity, rsp_err, rsp_timeout;
  logic raid_read_en, raid_write_en;
  logic [31:0] raid_addr, raid_din;
  logic [31:0] raid_dout = '0;
  logic raid_busy;
  logic raid_parity = 1'b0;
  logic raid_err = 1'b0;

  always #5 clk = ~clk;

  raid_host_arbiter #(.NREQ(NREQ), .OP_TIMEOUT(OP_TIMEOUT), .DRAIN_LAT(DRAIN_LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_din(req_din),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_parity(rsp_parity), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .raid_read_en(raid_read_en), .raid_write_en(raid_write_en),
    .raid_addr(raid_addr), .raid_din(raid_din), .raid_dout(raid_dout),
    .raid_busy(raid_busy), .raid_parity(raid_parity), .raid_err(raid_err)
  );

  // Controller model: busy rises in the strobe cycle and lasts busy_cyc cycles.
  logic force_busy = 1'b0;
  logic model_silent = 1'b0;
  logic model_busy = 1'b0;
  int busy_cyc = 3;
  int busy_left = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int strobe_cyc = 0;
  int both_err = 0;
  logic strobe_wr = 1'b0;
  logic [31:0] strobe_addr = '0;
  logic [31:0] strobe_din = '0;

  assign raid_busy = force_busy | model_busy;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (raid_read_en || raid_write_en) begin
      strobe_cnt++;
      strobe_cyc = cyc;
      strobe_wr = raid_write_en;
      strobe_addr = raid_addr;
      strobe_din = raid_din;
      if (raid_read_en && raid_write_en) both_err++;
      if (!model_silent) busy_left = busy_cyc;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    model_busy = (busy_left > 0);
  end

  int rsp_cnt = 0;
  int bus_viol = 0;
  int ready_viol = 0;
  int grant_log[$];

  always @(negedge clk) begin
    if (rsp_valid != '0) begin
      rsp_cnt++;
      if ($countones(rsp_valid) != 1) bus_viol++;
    end else if (rsp_data != 32'h0 || rsp_parity || rsp_err || rsp_timeout) begin
      bus_viol++;
    end
    if (req_ready != '0) begin
      if ($countones(req_ready) != 1) ready_viol++;
      for (int k = 0; k < NREQ; k++) if (req_ready[k]) grant_log.push_back(k);
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] addr, input logic [31:0] din);
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[32*i +: 32] = addr;
    req_din[32*i +: 32] = din;
  endtask

  task automatic wait_ready(output logic [NREQ-1:0] seen);
    seen = '0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        seen = req_ready;
        break;
      end
    end
  endtask

  task automatic wait_rsp(input int limit, output logic [NREQ-1:0] v, output logic [31:0] d,
                          output logic p, output logic e, output logic t, output int lat,
                          output logic [31:0] a);
    v = '0; d = '0; p = 1'b0; e = 1'b0; t = 1'b0; lat = -1; a = '0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        v = rsp_valid; d = rsp_data; p = rsp_parity; e = rsp_err; t = rsp_timeout;
        lat = cyc - strobe_cyc; a = raid_addr;
        break;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({req_ready, rsp_valid, rsp_parity, rsp_err, rsp_timeout,
                             raid_read_en, raid_write_en}), 64'h0);
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'h0);
    chk({tag, "_raid_addr"}, 64'(raid_addr), 64'h0);
    chk({tag, "_raid_din"}, 64'(raid_din), 64'h0);
  endtask

  typedef struct {
    int          idx;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] rdata;
    logic        par;
    logic        err;
    logic [31:0] exp_data;
    logic        exp_par;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  logic [NREQ-1:0] seen, rv, hold;
  logic [31:0] rd, ra;
  logic rp, re, rt;
  int lat, sc0, rc0, g;

  initial begin
    vecs[0] = '{0, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1] = '{1, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h1122_3344, 1'b0, 1'b0, 32'h1122_3344, 1'b0, 1'b0};
    vecs[2] = '{2, 1'b0, 32'h0000_0030, 32'h0000_0000, 32'hCAFE_F00D, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0};
    vecs[3] = '{3, 1'b1, 32'h0000_0040, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
    vecs[4] = '{3, 1'b0, 32'h0000_0044, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b1};
    vecs[5] = '{0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h8000_0001, 1'b0, 1'b0, 32'h8000_0001, 1'b0, 1'b0};

    // Power-up: controller busy, request already pending.
    force_busy = 1'b1;
    raid_dout = 32'h0BAD_F00D;
    set_req(0, 1'b0, 32'h0000_0008, 32'h0);
    @(negedge clk);
    chk_all_zero("in_reset");
    @(posedge clk); #1 reset = 1'b0;
    hold = '0;
    repeat (6) begin
      @(negedge clk);
      hold |= req_ready;
    end
    chk("busy_blocks_grant", 64'(hold), 64'h0);
    @(posedge clk); #1 force_busy = 1'b0;
    @(negedge clk);
    chk("ready_after_busy", 64'(req_ready), 64'b0001);
    @(posedge clk); #1 req_valid = '0;
    wait_rsp(50, rv, rd, rp, re, rt, lat, ra);
    chk("pwrup_rsp_valid", 64'(rv), 64'b0001);
    chk("pwrup_rsp_data", 64'(rd), 64'h0BAD_F00D);

    // All four held valid after reset: pointer starts at 0.
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    grant_log.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 32'h100 + 32'(i), 32'h0);
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      if (grant_log.size() >= 4) break;
    end
    #1 req_valid = '0;
    wait_rsp(50, rv, rd, rp, re, rt, lat, ra);
    chk("grant_count", 64'(grant_log.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      g = (k < grant_log.size()) ? grant_log[k] : -1;
`ifdef RAID_ARB_STRICT_PRIO_EN
      chk($sformatf("grant_order_%0d", k), 64'(g), 64'd0);
`else
      chk($sformatf("grant_order_%0d", k), 64'(g), 64'(k));
`endif
    end

    // Single-requester vectors.
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      raid_dout = vecs[k].rdata;
      raid_parity = vecs[k].par;
      raid_err = vecs[k].err;
      sc0 = strobe_cnt;
      set_req(vecs[k].idx, vecs[k].wr, vecs[k].addr, vecs[k].din);
      wait_ready(seen);
      chk($sformatf("v%0d_ready", k), 64'(seen), 64'(4'b0001 << vecs[k].idx));
      @(posedge clk); #1 req_valid = '0;
      wait_rsp(50, rv, rd, rp, re, rt, lat, ra);
      chk($sformatf("v%0d_strobes", k), 64'(strobe_cnt - sc0), 64'd1);
      chk($sformatf("v%0d_strobe_wr", k), 64'(strobe_wr), 64'(vecs[k].wr));
      chk($sformatf("v%0d_strobe_addr", k), 64'(strobe_addr), 64'(vecs[k].addr));
      if (vecs[k].wr) chk($sformatf("v%0d_strobe_din", k), 64'(strobe_din), 64'(vecs[k].din));
      chk($sformatf("v%0d_rsp_valid", k), 64'(rv), 64'(4'b0001 << vecs[k].idx));
      chk($sformatf("v%0d_rsp_data", k), 64'(rd), 64'(vecs[k].exp_data));
      chk($sformatf("v%0d_rsp_parity", k), 64'(rp), 64'(vecs[k].exp_par));
      chk($sformatf("v%0d_rsp_err", k), 64'(re), 64'(vecs[k].exp_err));
      chk($sformatf("v%0d_rsp_timeout", k), 64'(rt), 64'h0);
      chk($sformatf("v%0d_addr_held", k), 64'(ra), 64'(vecs[k].addr));
      // strobe cycle + busy cycles + drain + one registered response cycle
      chk($sformatf("v%0d_latency", k), 64'(lat), 64'(busy_cyc + DRAIN_LAT + 1));
      @(negedge clk);
      chk($sformatf("v%0d_rsp_one_cycle", k), 64'(rsp_valid), 64'h0);
    end

    // Controller never raises busy: abandoned after OP_TIMEOUT counted cycles.
    @(posedge clk); #1;
    model_silent = 1'b1;
    raid_dout = 32'hFFFF_FFFF;
    raid_parity = 1'b1;
    raid_err = 1'b1;
    set_req(1, 1'b0, 32'h0000_0050, 32'h0);
    wait_ready(seen);
    @(posedge clk); #1 req_valid = '0;
    wait_rsp(1200, rv, rd, rp, re, rt, lat, ra);
    chk("tmo_rsp_valid", 64'(rv), 64'b0010);
    chk("tmo_flag", 64'(rt), 64'h1);
    chk("tmo_data", 64'(rd), 64'h0);
    chk("tmo_parity", 64'(rp), 64'h0);
    chk("tmo_err", 64'(re), 64'h0);
    chk("tmo_latency", 64'(lat), 64'(OP_TIMEOUT + 1));
    @(posedge clk); #1;
    model_silent = 1'b0;
    raid_parity = 1'b0;
    raid_err = 1'b0;
    set_req(2, 1'b1, 32'h0000_0060, 32'h5555_AAAA);
    wait_ready(seen);
    chk("post_tmo_ready", 64'(seen), 64'b0100);
    @(posedge clk); #1 req_valid = '0;
    wait_rsp(50, rv, rd, rp, re, rt, lat, ra);
    chk("post_tmo_rsp_valid", 64'(rv), 64'b0100);
    chk("post_tmo_timeout", 64'(rt), 64'h0);

    // Reset while waiting for busy to fall.
    @(posedge clk); #1;
    busy_cyc = 20;
    sc0 = strobe_cnt;
    set_req(2, 1'b0, 32'h0000_0070, 32'h0);
    wait_ready(seen);
    @(posedge clk); #1 req_valid = '0;
    for (int n = 0; n < 20; n++) begin
      if (strobe_cnt != sc0) break;
      @(posedge clk); #1;
    end
    chk("rst_op_strobed", 64'(strobe_cnt - sc0), 64'd1);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    busy_cyc = 3;
    @(negedge clk);
    chk_all_zero("mid_op_reset");
    @(posedge clk); #1 reset = 1'b0;
    rc0 = rsp_cnt;
    repeat (30) @(posedge clk);
    chk("dropped_op_no_rsp", 64'(rsp_cnt - rc0), 64'h0);
    #1;
    raid_dout = 32'h7777_0001;
    set_req(3, 1'b0, 32'h0000_0080, 32'h0);
    wait_ready(seen);
    chk("after_reset_ready", 64'(seen), 64'b1000);
    @(posedge clk); #1 req_valid = '0;
    wait_rsp(50, rv, rd, rp, re, rt, lat, ra);
    chk("after_reset_rsp_valid", 64'(rv), 64'b1000);
    chk("after_reset_rsp_data", 64'(rd), 64'h7777_0001);

    repeat (3) @(posedge clk);
    chk("ready_onehot", 64'(ready_viol), 64'h0);
    chk("rsp_bus_idle_zero", 64'(bus_viol), 64'h0);
    chk("no_dual_strobe", 64'(both_err), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
